// File: rtl/hazard_pkg.sv
// Shared hazard-detection types and the register match helper used by the stall
// and forwarding logic.
package hazard_pkg;

    localparam int unsigned REG_W = 5;

    typedef enum logic [1:0] {
        HZ_RUN      = 2'd0,
        HZ_BR_LD2   = 2'd1,
        HZ_MEM_WAIT = 2'd2
    } hzState_t;

    localparam logic [REG_W-1:0] REG_ZERO = 5'd0;

    // True when a producer destination r feeds a source the ID instruction reads; $0 never matches.
    function automatic logic regMatch(
        input logic [REG_W-1:0] r,
        input logic [REG_W-1:0] rs,
        input logic [REG_W-1:0] rt,
        input logic             usesRt
    );
        return (r != REG_ZERO) && ((r == rs) || (usesRt && (r == rt)));
    endfunction

endpackage

// File: rtl/hazard_sat_counter.sv
// Saturating up-counter with synchronous clear, used for stall-cycle statistics.
module hazard_sat_counter #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    output logic [CNT_W-1:0] count
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (en && (count != CNT_MAX)) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/hazard_stall_unit.sv
// Pipeline stall/flush controller: load-use, branch-in-ID on in-flight results,
// and data-memory wait handling, with a saturating stall-cycle counter.
module hazard_stall_unit
    import hazard_pkg::*;
#(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ID_EX__MemRead,
    input  logic             ID_EX__RegWrite,
    input  logic [4:0]       ID_EX__rWR,
    input  logic             EX_MEM__MemRead,
    input  logic [4:0]       EX_MEM__rWR,
    input  logic [4:0]       IF_ID__rs,
    input  logic [4:0]       IF_ID__rt,
    input  logic             IF_ID__UsesRt,
    input  logic             IF_ID__Branch,
    input  logic             ID__BranchTaken,
    input  logic             dmem_req,
    input  logic             dmem_ready,
    output logic             PCWrite,
    output logic             IF_ID__Write,
    output logic             ID_EX__Bubble,
    output logic             IF_ID__Flush,
    output logic             BackHold,
    output logic [CNT_W-1:0] STALL_CNT
);

    hzState_t state;
    hzState_t nextState;

    logic exMatch;
    logic memMatch;
    logic loadUse;
    logic branchEx;
    logic branchLoad;
    logic branchMem;
    logic memWait;
    logic doStall;
    logic doFreeze;

    assign exMatch    = regMatch(ID_EX__rWR, IF_ID__rs, IF_ID__rt, IF_ID__UsesRt);
    assign memMatch   = regMatch(EX_MEM__rWR, IF_ID__rs, IF_ID__rt, IF_ID__UsesRt);
    assign loadUse    = ID_EX__MemRead && exMatch;
    assign branchEx   = IF_ID__Branch && ID_EX__RegWrite && !ID_EX__MemRead && exMatch;
    assign branchLoad = IF_ID__Branch && ID_EX__MemRead && exMatch;
    assign branchMem  = IF_ID__Branch && EX_MEM__MemRead && memMatch;
    assign memWait    = dmem_req && !dmem_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= HZ_RUN;
        end else begin
            state <= nextState;
        end
    end

    // Next state plus Mealy outputs; reset forcing overrides everything last.
    always_comb begin
        nextState     = state;
        doStall       = 1'b0;
        doFreeze      = 1'b0;
        PCWrite       = 1'b1;
        IF_ID__Write  = 1'b1;
        ID_EX__Bubble = 1'b0;
        BackHold      = 1'b0;
        IF_ID__Flush  = IF_ID__Branch && ID__BranchTaken;

        case (state)
            HZ_RUN: begin
                if (memWait) begin
                    doFreeze  = 1'b1;
                    nextState = HZ_MEM_WAIT;
                end else if (branchLoad) begin
                    doStall   = 1'b1;
                    nextState = HZ_BR_LD2;
                end else if (loadUse || branchEx || branchMem) begin
                    doStall   = 1'b1;
                end
            end
            HZ_BR_LD2: begin
                if (memWait) begin
                    doFreeze  = 1'b1;
                    nextState = HZ_MEM_WAIT;
                end else begin
                    doStall   = 1'b1;
                    nextState = HZ_RUN;
                end
            end
            HZ_MEM_WAIT: begin
                // The completing cycle is frozen too; ID hazards are re-checked next cycle.
                doFreeze = 1'b1;
                if (!memWait) begin
                    nextState = HZ_RUN;
                end
            end
            default: begin
                nextState = HZ_RUN;
            end
        endcase

        if (doStall || doFreeze) begin
            PCWrite       = 1'b0;
            IF_ID__Write  = 1'b0;
            IF_ID__Flush  = 1'b0;
            ID_EX__Bubble = doStall;
            BackHold      = doFreeze;
        end

        if (reset) begin
            PCWrite       = 1'b0;
            IF_ID__Write  = 1'b0;
            ID_EX__Bubble = 1'b1;
            IF_ID__Flush  = 1'b1;
            BackHold      = 1'b0;
        end
    end

    hazard_sat_counter #(
        .CNT_W(CNT_W)
    ) u_stallCnt (
        .clk  (clk),
        .reset(reset),
        .en   (!PCWrite),
        .count(STALL_CNT)
    );

endmodule
